// File: rtl/mlp_sequencer.sv
// rtl/mlp_sequencer.sv - two-layer MLP tile/command sequencer (FC1 -> activation -> FC2)
//
// Purpose: walks the FC1 and FC2 matrix products of one MLP block as a stream of
// MAC commands (row, output tile, reduction index), waits for the MAC engine to
// write back every tile, and in between issues one activation transfer per FC1
// output tile.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   init, n_tokens        start request and token row count (accepted only when ready)
//   ready, done, error    idle / one-cycle completion pulse / one-cycle rejected-init pulse
//   phase                 0 idle/done, 1 FC1, 2 activation, 3 FC2
//   cmd_valid, cmd_ready  MAC command handshake
//   cmd_layer, cmd_row, cmd_tile, cmd_k, cmd_first, cmd_last   MAC command fields
//   res_valid             one pulse per tile written back by the MAC engine
//   act_valid, act_ready, act_row, act_tile                    activation handshake

module mlp_sequencer #(
  parameter int D_MODEL = 192,
  parameter int TILE    = 8,
  parameter int N_MAX   = 197,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [CW-1:0] n_tokens,
  output logic          ready,
  output logic          done,
  output logic          error,
  output logic [1:0]    phase,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_layer,
  output logic [CW-1:0] cmd_row,
  output logic [CW-1:0] cmd_tile,
  output logic [CW-1:0] cmd_k,
  output logic          cmd_first,
  output logic          cmd_last,
  input  logic          res_valid,
  output logic          act_valid,
  input  logic          act_ready,
  output logic [CW-1:0] act_row,
  output logic [CW-1:0] act_tile
);

  localparam int H  = 4 * D_MODEL;
  localparam int T1 = H / TILE;        // output tiles of FC1
  localparam int T2 = D_MODEL / TILE;  // output tiles of FC2

  localparam logic [CW-1:0] K1_LAST = CW'(D_MODEL - 1);
  localparam logic [CW-1:0] K2_LAST = CW'(H - 1);
  localparam logic [CW-1:0] T1_LAST = CW'(T1 - 1);
  localparam logic [CW-1:0] T2_LAST = CW'(T2 - 1);
  localparam logic [CW-1:0] N_LIMIT = CW'(N_MAX);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FC1      = 3'd1;
  localparam logic [2:0] S_FC1_WAIT = 3'd2;
  localparam logic [2:0] S_ACT      = 3'd3;
  localparam logic [2:0] S_FC2      = 3'd4;
  localparam logic [2:0] S_FC2_WAIT = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] n_reg;
  logic [CW-1:0] row;
  logic [CW-1:0] tile;
  logic [CW-1:0] k;
  logic [CW-1:0] res_cnt;
  logic          error_q;

  logic          in_fc1;
  logic          in_fc2;
  logic          in_act;
  logic [CW-1:0] k_last;
  logic [CW-1:0] tile_last;
  logic          row_at_last;
  logic          k_at_last;
  logic          tile_at_last;
  logic          cmd_fire;
  logic          act_fire;
  logic          cmd_done;
  logic          act_done;
  logic          counting;
  logic [CW-1:0] res_next;
  logic [2*CW-1:0] target1;
  logic [2*CW-1:0] target2;
  logic          hit1;
  logic          hit2;
  logic          init_legal;

  always_comb begin
    in_fc1       = (state == S_FC1);
    in_fc2       = (state == S_FC2);
    in_act       = (state == S_ACT);
    k_last       = in_fc2 ? K2_LAST : K1_LAST;
    // Activation walks the FC1 output tiles, so it shares the FC1 tile bound.
    tile_last    = in_fc2 ? T2_LAST : T1_LAST;
    row_at_last  = (row == n_reg - 1'b1);
    k_at_last    = (k == k_last);
    tile_at_last = (tile == tile_last);
    cmd_fire     = (in_fc1 | in_fc2) & cmd_ready;
    act_fire     = in_act & act_ready;
    cmd_done     = cmd_fire & k_at_last & tile_at_last & row_at_last;
    act_done     = act_fire & tile_at_last & row_at_last;
    counting     = (state == S_FC1) | (state == S_FC1_WAIT) |
                   (state == S_FC2) | (state == S_FC2_WAIT);
    res_next     = res_cnt + {{(CW-1){1'b0}}, counting & res_valid};
    target1      = (2*CW)'(n_reg) * (2*CW)'(T1);
    target2      = (2*CW)'(n_reg) * (2*CW)'(T2);
    // Compare the count including this cycle's pulse so the wait state exits
    // in the same cycle the final write-back arrives.
    hit1         = ({{CW{1'b0}}, res_next} == target1);
    hit2         = ({{CW{1'b0}}, res_next} == target2);
    init_legal   = (n_tokens != '0) && (n_tokens <= N_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      n_reg   <= '0;
      row     <= '0;
      tile    <= '0;
      k       <= '0;
      res_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      res_cnt <= res_next;
      case (state)
        S_IDLE: begin
          if (init) begin
            if (init_legal) begin
              n_reg   <= n_tokens;
              row     <= '0;
              tile    <= '0;
              k       <= '0;
              res_cnt <= '0;
              state   <= S_FC1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_FC1, S_FC2: begin
          if (cmd_fire) begin
            // k innermost, then tile, then row; every counter wraps to zero
            // on the final command so the next phase starts from the origin.
            if (k_at_last) begin
              k <= '0;
              if (tile_at_last) begin
                tile <= '0;
                if (row_at_last) begin
                  row <= '0;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                tile <= tile + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
            if (cmd_done) begin
              state <= in_fc1 ? S_FC1_WAIT : S_FC2_WAIT;
            end
          end
        end
        S_FC1_WAIT: begin
          if (hit1) begin
            state <= S_ACT;
          end
        end
        S_ACT: begin
          if (act_fire) begin
            if (tile_at_last) begin
              tile <= '0;
              if (row_at_last) begin
                row <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              tile <= tile + 1'b1;
            end
            if (act_done) begin
              res_cnt <= '0;
              state   <= S_FC2;
            end
          end
        end
        S_FC2_WAIT: begin
          if (hit2) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          res_cnt <= '0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ready     = (state == S_IDLE);
    done      = (state == S_DONE);
    error     = error_q;
    case (state)
      S_FC1, S_FC1_WAIT: phase = 2'd1;
      S_ACT:             phase = 2'd2;
      S_FC2, S_FC2_WAIT: phase = 2'd3;
      default:           phase = 2'd0;
    endcase
    // Fields are driven straight from the counters, which only move on a
    // handshake, so they are inherently stable while stalled.
    cmd_valid = in_fc1 | in_fc2;
    cmd_layer = in_fc2;
    cmd_row   = cmd_valid ? row  : '0;
    cmd_tile  = cmd_valid ? tile : '0;
    cmd_k     = cmd_valid ? k    : '0;
    cmd_first = cmd_valid & (k == '0);
    cmd_last  = cmd_valid & k_at_last;
    act_valid = in_act;
    act_row   = in_act ? row  : '0;
    act_tile  = in_act ? tile : '0;
  end

endmodule

// File: tb/tb_mlp_sequencer.sv
// tb/tb_mlp_sequencer.sv - directed self-checking bench for mlp_sequencer (D_MODEL=8, TILE=4)
//
// Purpose: drives directed scenarios (normal pass, random stalls, delayed
// write-back, illegal init, reset mid-run, init while busy) and checks every
// accepted command and activation transfer against the nested-loop order.
// Ports: none (top-level bench).

module tb_mlp_sequencer;

  localparam int D  = 8;
  localparam int TL = 4;
  localparam int NM = 197;
  localparam int CW = 16;
  localparam int H  = 4 * D;
  localparam int T1 = H / TL;
  localparam int T2 = D / TL;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [CW-1:0] n_tokens;
  logic          ready;
  logic          done;
  logic          error;
  logic [1:0]    phase;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_layer;
  logic [CW-1:0] cmd_row;
  logic [CW-1:0] cmd_tile;
  logic [CW-1:0] cmd_k;
  logic          cmd_first;
  logic          cmd_last;
  logic          res_valid;
  logic          act_valid;
  logic          act_ready;
  logic [CW-1:0] act_row;
  logic [CW-1:0] act_tile;

  mlp_sequencer #(.D_MODEL(D), .TILE(TL), .N_MAX(NM), .CW(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .n_tokens(n_tokens),
    .ready(ready), .done(done), .error(error), .phase(phase),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_layer(cmd_layer),
    .cmd_row(cmd_row), .cmd_tile(cmd_tile), .cmd_k(cmd_k),
    .cmd_first(cmd_first), .cmd_last(cmd_last), .res_valid(res_valid),
    .act_valid(act_valid), .act_ready(act_ready), .act_row(act_row), .act_tile(act_tile)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int due_q[$];
  bit lay_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_pass(input int n, input bit stall, input int hold,
                          input bit busy_init, input bit abort);
    int c1 = 0, c2 = 0, a = 0, r1 = 0, r2 = 0, done_cnt = 0;
    int idx, kk, tt, due;
    bit fin = 0, pulsed = 0, exp_layer, cr, ar, rv, pcs = 0, pas = 0;
    logic [3*CW+3:0] cv, pcv;
    logic [2*CW:0]   av, pav;
    pcv = '0;
    pav = '0;
    init = 1'b1; n_tokens = CW'(n); cmd_ready = 1'b0; act_ready = 1'b0; res_valid = 1'b0;
    tick();
    init = 1'b0;
    chk("accept_cmd_valid", cmd_valid, 1);
    chk("accept_phase", phase, 1);
    chk("accept_ready", ready, 0);
    chk("accept_first", cmd_first, 1);
    for (int t = 0; t < 6000 && !fin; t++) begin
      cr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ar = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cv = {cmd_valid, cmd_layer, cmd_row, cmd_tile, cmd_k, cmd_first, cmd_last};
      av = {act_valid, act_row, act_tile};
      chk("valid_excl", cmd_valid & act_valid, 0);
      if (pcs) chk("cmd_stable", cv, pcv);
      if (pas) chk("act_stable", av, pav);
      if (abort && cmd_valid && cmd_layer && c2 >= 5) begin
        reset = 1'b1; cmd_ready = 1'b1; act_ready = 1'b0; res_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_ready", ready, 1);
        chk("rst_phase", phase, 0);
        due_q.delete();
        lay_q.delete();
        return;
      end
      if (cmd_valid && cr) begin
        exp_layer = (c1 == n * T1 * D);
        chk("cmd_layer", cmd_layer, exp_layer);
        if (!exp_layer) begin idx = c1; kk = D; tt = T1; c1++; end
        else begin idx = c2; kk = H; tt = T2; c2++; chk("fc2_after_act", a, n * T1); end
        chk("cmd_row", cmd_row, idx / (kk * tt));
        chk("cmd_tile", cmd_tile, (idx / kk) % tt);
        chk("cmd_k", cmd_k, idx % kk);
        chk("cmd_first", cmd_first, (idx % kk) == 0);
        chk("cmd_last", cmd_last, (idx % kk) == kk - 1);
        chk("cmd_phase", phase, exp_layer ? 3 : 1);
        if ((idx % kk) == kk - 1) begin
          due = cyc + 2;
          if (!exp_layer && idx == n * T1 * D - 1) due += hold;
          due_q.push_back(due);
          lay_q.push_back(exp_layer);
        end
      end
      if (c1 == n * T1 * D && r1 < n * T1) begin
        chk("wait1_act_valid", act_valid, 0);
        chk("wait1_phase", phase, 1);
      end
      if (act_valid && ar) begin
        chk("act_row", act_row, a / T1);
        chk("act_tile", act_tile, a % T1);
        chk("act_after_res", r1, n * T1);
        chk("act_phase", phase, 2);
        a++;
      end
      if (busy_init && act_valid && a == 3 && !pulsed) begin
        init = 1'b1; n_tokens = 16'd1; pulsed = 1'b1;
        chk("busy_ready", ready, 0);
      end else begin
        init = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("done_ready", ready, 0);
        chk("fc1_cmds", c1, n * T1 * D);
        chk("fc2_cmds", c2, n * T2 * H);
        chk("act_count", a, n * T1);
        chk("fc2_results", r2, n * T2);
        fin = 1'b1;
      end
      rv = (due_q.size() > 0) && (due_q[0] <= cyc);
      if (rv) begin
        if (lay_q[0]) r2++; else r1++;
        void'(due_q.pop_front());
        void'(lay_q.pop_front());
      end
      cmd_ready = cr; act_ready = ar; res_valid = rv;
      pcs = cmd_valid && !cr; pcv = cv;
      pas = act_valid && !ar; pav = av;
      tick();
    end
    init = 1'b0; res_valid = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("post_ready", ready, 1);
    chk("post_phase", phase, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_cnt++;
      chk("idle_cmd_valid", cmd_valid, 0);
    end
    chk("done_once", done_cnt, 1);
  endtask

  task automatic illegal_init(input int n);
    init = 1'b1; n_tokens = CW'(n);
    tick();
    init = 1'b0;
    chk("ill_error", error, 1);
    chk("ill_ready", ready, 1);
    chk("ill_cmd_valid", cmd_valid, 0);
    chk("ill_phase", phase, 0);
    tick();
    chk("ill_error_pulse", error, 0);
    chk("ill_cmd_idle", cmd_valid, 0);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; n_tokens = '0;
    cmd_ready = 1'b0; act_ready = 1'b0; res_valid = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_phase", phase, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_first_last", {cmd_first, cmd_last}, 0);
    chk("rst_cmd_idx", {cmd_layer, cmd_row, cmd_tile, cmd_k}, 0);
    chk("rst_act_idx", {act_row, act_tile}, 0);
    reset = 1'b0;
    tick();

    run_pass(2, 0, 0, 0, 0);
    run_pass(2, 1, 0, 0, 0);
    run_pass(2, 0, 50, 0, 0);
    illegal_init(0);
    illegal_init(NM + 1);
    run_pass(2, 0, 0, 0, 1);
    run_pass(1, 0, 0, 0, 0);
    run_pass(2, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Parameter D_MODEL, default 192: embedding width; hidden width H = 4*D_MODEL.
REQ-002 Parameter TILE, default 8: output columns per MAC tile; D_MODEL SHALL be divisible by TILE.
REQ-003 Parameter N_MAX, default 197: maximum token rows n.
REQ-004 Parameter CW, default 16: width of all index/count ports.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port init  input  1  start request; sampled only when ready=1.
REQ-008 Port n_tokens  input  CW  row count n; latched on accepted init.
REQ-009 Port ready  output  1  idle and able to accept init.
REQ-010 Port done  output  1  one-cycle pulse when the full MLP pass completes.
REQ-011 Port error  output  1  one-cycle pulse on rejected init.
REQ-012 Port phase  output  2  0=IDLE/DONE, 1=FC1, 2=ACT, 3=FC2.
REQ-013 Port cmd_valid / cmd_ready  output / input  1 each  MAC command handshake.
REQ-014 Port cmd_layer  output  1  0=FC1 (W1,b1), 1=FC2 (W2,b2).
REQ-015 Ports cmd_row, cmd_tile, cmd_k  output  CW each  token row, output column tile, reduction index.
REQ-016 Ports cmd_first / cmd_last  output  1 each  clear accumulator / write back tile (bias added by engine).
REQ-017 Port res_valid  input  1  one pulse per completed tile written back by the MAC engine.
REQ-018 Ports act_valid / act_ready  output / input  1 each  activation (ReLU/GeLU) handshake; act_row, act_tile output CW each.

Function
REQ-019 States: IDLE, FC1, FC1_WAIT, ACT, FC2, FC2_WAIT, DONE.
REQ-020 IDLE: ready=1; init=1 with 1<=n_tokens<=N_MAX latches n and moves to FC1; cmd_valid is high in the next cycle.
REQ-021 init=1 in IDLE with n_tokens=0 or >N_MAX: error=1 for one cycle; state stays IDLE.
REQ-022 init while ready=0: ignored, no effect.
REQ-023 FC1 loop order: row 0..n-1 (outer), tile 0..H/TILE-1, k 0..D_MODEL-1 (inner).
REQ-024 FC2 loop order: row 0..n-1, tile 0..D_MODEL/TILE-1, k 0..H-1.
REQ-025 Indices advance only on cmd_valid&cmd_ready; all cmd_* outputs hold stable while cmd_valid=1 and cmd_ready=0.
REQ-026 cmd_first=1 exactly when k=0; cmd_last=1 exactly when k=K-1 (K = D_MODEL for FC1, H for FC2).
REQ-027 After the final command of FC1/FC2 is accepted, cmd_valid drops the next cycle and the FSM enters FC1_WAIT/FC2_WAIT.
REQ-028 Result counter counts res_valid during FC1, FC1_WAIT, FC2 and FC2_WAIT; it clears on each phase entry.
REQ-029 FC1_WAIT exits to ACT in the cycle the count reaches n*H/TILE.
REQ-030 FC2_WAIT exits to DONE in the cycle the count reaches n*D_MODEL/TILE.
REQ-031 res_valid in any other state is ignored.
REQ-032 ACT issues n*H/TILE transfers with row outer and tile inner; act_* are stable under stall; the last accepted transfer moves the FSM to FC2.
REQ-033 DONE lasts one cycle with done=1 and ready=0, then returns to IDLE.
REQ-034 cmd_valid and act_valid are never high simultaneously, and never high outside FC1/FC2 and ACT respectively.
REQ-035 All counters are CW bits wide; products are computed in 2*CW bits; no wrap-around occurs for legal parameters.

Reset
REQ-036 reset=1 at any cycle, including mid-phase, forces IDLE on the next edge.
REQ-037 Reset values: ready=1, all counters 0, and all other outputs 0 (done, error, phase, cmd_valid, act_valid, cmd_first, cmd_last, and all index ports).

Verification (D_MODEL=8, TILE=4, so H=32)
REQ-038 Scenario 1, normal pass: init with n=2, cmd_ready=act_ready=1, engine returns res_valid per cmd_last.
- Expect 128 FC1 commands, then 16 results, then 16 ACT transfers.
- Expect 128 FC2 commands, then 4 results, then one done pulse, then ready=1.
REQ-039 Scenario 2, random stalls: toggle cmd_ready and act_ready randomly.
- Command sequence is identical to Scenario 1.
- Outputs are stable while stalled.
- First/last markers occur at k=0 and k=7 (FC1) and at k=0 and k=31 (FC2).
REQ-040 Scenario 3, delayed results: hold back the last FC1 res_valid by 50 cycles.
- FSM stays in FC1_WAIT and act_valid stays 0 until the 16th result arrives.
REQ-041 Scenario 4, illegal init: n_tokens=0, then n_tokens=N_MAX+1.
- Expect an error pulse each time, ready stays 1, and no commands are issued.
REQ-042 Scenario 5, reset mid-run: assert reset during FC2 with cmd_valid=1.
- Next cycle: cmd_valid=0, ready=1, phase=0.
- A subsequent init with n=1 completes normally.
REQ-043 Scenario 6, init while busy: pulse init during ACT.
- Ignored; exactly one done pulse occurs for the original run.
